// File: rtl/aes_pkg.sv
// Shared AES definitions: feeder FSM states, key-length codes, GF(2^8) arithmetic.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } feeder_state_e;

  localparam logic [3:0] NK4 = 4'd4;
  localparam logic [3:0] NK6 = 4'd6;
  localparam logic [3:0] NK8 = 4'd8;

  localparam int unsigned NR_MAX = 14;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_key_feeder_inv_mix_column_word.sv
// InvMixColumns on a single 32-bit column (row 0 in the top byte), purely combinational.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed_c
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Inverse MixColumns matrix rows {0e,0b,0d,09} rotated per output byte.
  always_comb begin
    mixed_c[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    mixed_c[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    mixed_c[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    mixed_c[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

endmodule

// File: rtl/aes_inv_key_feeder.sv
// Streams expanded round keys Nr..0 to the inverse cipher over valid/ready.
// Define AES_EQ_INV_KEY_EN to apply InvMixColumns to rounds 1..Nr-1
// (equivalent inverse cipher key conditioning).
module aes_inv_key_feeder
  import aes_pkg::*;
#(
  parameter int unsigned NW = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32*NW-1:0]  w,
  input  logic [3:0]        nk,
  input  logic              sched_done,
  input  logic              start,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [127:0]      rk,
  output logic [3:0]        rk_idx,
  output logic              rk_last,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AW = $clog2(NW);

  feeder_state_e state;
  logic [3:0]    nk_q;
  logic          sched_done_q;
  logic [3:0]    nr;
  logic [3:0]    load_idx;
  logic [127:0]  key_raw;
  logic [127:0]  key_cond;
  logic          nk_legal;
  logic          handshake;

  logic [31:0]   w_word [NW];

  // Unpack the flat expanded-key bus into addressable words.
  for (genvar k = 0; k < NW; k++) begin : g_unpack
    assign w_word[k] = w[32*k +: 32];
  end

  assign nr        = nk_q + 4'd6;
  assign nk_legal  = (nk == NK4) || (nk == NK6) || (nk == NK8);
  assign handshake = rk_valid && rk_ready;

  // Round whose key is loaded next: Nr when leaving WAIT, else the one below the current key.
  always_comb begin
    load_idx = (state == ST_WAIT) ? nr : (rk_idx - 4'd1);
    if (load_idx > 4'(NR_MAX)) load_idx = 4'(NR_MAX);
  end

  // Gather words 4*idx..4*idx+3, lowest address into the top of the key.
  for (genvar j = 0; j < 4; j++) begin : g_gather
    assign key_raw[127-32*j -: 32] = w_word[AW'({load_idx, 2'(j)})];
  end

`ifdef AES_EQ_INV_KEY_EN
  logic [127:0] key_mixed;
  logic         cond_en;

  for (genvar j = 0; j < 4; j++) begin : g_imc
    inv_mix_column_word u_imc (
      .col     (key_raw[32*j +: 32]),
      .mixed_c (key_mixed[32*j +: 32])
    );
  end

  // Outer rounds (Nr loaded from WAIT, 0 loaded in STREAM) bypass the mix.
  assign cond_en  = (state == ST_STREAM) && (load_idx != 4'd0);
  assign key_cond = cond_en ? key_mixed : key_raw;
`else
  assign key_cond = key_raw;
`endif

  // Feeder FSM with registered handshake outputs; abort on loss of sched_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      nk_q         <= 4'd0;
      sched_done_q <= 1'b0;
      rk           <= 128'd0;
      rk_valid     <= 1'b0;
      rk_idx       <= 4'd0;
      rk_last      <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      sched_done_q <= sched_done;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            nk_q <= nk;
            if (!nk_legal) begin
              err <= 1'b1;
            end else begin
              err   <= 1'b0;
              state <= ST_WAIT;
              busy  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (sched_done_q && !sched_done) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            err      <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (sched_done) begin
            rk       <= key_cond;
            rk_idx   <= nr;
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (!sched_done) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            err      <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (handshake) begin
            if (rk_idx == 4'd0) begin
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              rk      <= key_cond;
              rk_idx  <= load_idx;
              rk_last <= (rk_idx == 4'd1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_inv_key_feeder.md
# aes_inv_key_feeder

Read-side counterpart of the AES key-expansion block for the decryption path. It takes the full expanded-key bus (60 words) from the key schedule once the schedule reports completion. It then streams the Nr+1 round keys to the inverse-cipher datapath in reverse order, from round Nr down to round 0, over a valid/ready handshake. It sits between the key schedule and the inverse-round engine, and owns round-key ordering and optional equivalent-inverse-cipher key conditioning.

## Interface
Parameters:
- `NW`, default 60, number of 32-bit words on the expanded-key bus (4*(14+1)).

Ports:
- `clk`, in, 1, rising-edge clock.
- `rst`, in, 1, reset; synchronous, active-high.
- `w`, in, 32*NW, expanded key. Word k is at bits [32k+31:32k].
- `nk`, in, 4, key length in words. Legal values are 4, 6 and 8.
- `sched_done`, in, 1, key schedule complete; `w` is stable while this is high.
- `start`, in, 1, request a new reverse key stream.
- `rk_valid`, out, 1, round key present on `rk`.
- `rk_ready`, in, 1, consumer accepts `rk`.
- `rk`, out, 128, round key. Word 4i is at [127:96] and word 4i+3 is at [31:0].
- `rk_idx`, out, 4, round number of `rk`.
- `rk_last`, out, 1, high with the round-0 key.
- `busy`, out, 1, not in IDLE.
- `err`, out, 1, sticky error. Cleared by the next accepted `start` or by `rst`.

## Operation
- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - `start`=1 latches `nk` and clears `err`.
  - If `nk` is illegal: `err`←1 and the FSM stays in IDLE.
  - Otherwise: move to WAIT.
- `start` is ignored outside IDLE.
- WAIT:
  - On `sched_done`=1: `idx`←Nr (Nr = nk_latched+6), load `rk` from words 4Nr..4Nr+3, `rk_valid`←1, move to STREAM.
- STREAM:
  - `rk`, `rk_idx` and `rk_last` are held stable while `rk_valid`&&!`rk_ready`.
  - On a handshake with `idx`=0: `rk_valid`←0, move to IDLE.
  - On a handshake with `idx`>0: `idx`←`idx`-1 and load the next key in the same cycle.
- Abort: if `sched_done` falls in WAIT or STREAM, then on the next cycle `rk_valid`←0, `err`←1, and the FSM returns to IDLE.
- `rk_last` = (`rk_idx`==0) && `rk_valid`.
- Word addressing: 4*idx+j for j = 0..3. The maximum address is 59, so no out-of-range read occurs for legal nk.

## Timing
- Reset values:
  - `rk_valid`=0, `rk`=0, `rk_idx`=0, `rk_last`=0, `busy`=0, `err`=0.
  - FSM in IDLE.
- `rst` takes priority over every other event, including mid-stream. The stream is dropped and no partial key remains visible.
- `start` sampled at edge t → `busy`=1 after t.
- `sched_done` high sampled at edge t in WAIT → `rk_valid`=1 with key Nr after edge t.
- If `sched_done` is already high when `start` is accepted, the first key appears 2 cycles after `start`.
- With `rk_ready` held at 1, one key transfers per cycle. Nr+1 consecutive transfers, no bubbles.
- All outputs are registered. There is no combinational path from `rk_ready` to `rk` or `rk_valid`.
- Abort and handshake in the same cycle: the abort wins, and the accepted key is the last one the consumer should use.

## Configuration
- With `AES_EQ_INV_KEY_EN` defined:
  - Keys for rounds 1..Nr-1 pass through InvMixColumns (each 32-bit column independently) before being registered.
  - Rounds Nr and 0 pass through unchanged.
  - This supports the FIPS-197 equivalent inverse cipher.
  - Latency and handshake timing are identical to the macro-undefined case.
- Without the macro, all keys are forwarded verbatim.

## Structure
- Shared package `aes_pkg`:
  - FSM state typedef.
  - `NK4`/`NK6`/`NK8` constants.
  - `NR_MAX`=14.
  - GF(2^8) `xtime`/multiply functions, shared with the cipher rounds.
- Sub-module `inv_mix_column_word`:
  - One 32-bit column, combinational.
  - Instantiated 4× only under `AES_EQ_INV_KEY_EN`.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, nk=4, `sched_done`=1, `rk_ready`=1, macro off:
  - 11 keys, `rk_idx` 10→0.
  - First key d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Last key 2b7e151628aed2a6abf7158809cf4f3c with `rk_last`=1.
- nk=8, 256-bit key 603deb10…0914dff4:
  - 15 keys.
  - Round-0 key 603deb1015ca71be2b73aef0857d7781.
  - `busy` drops the cycle after the last handshake.
- Backpressure: `rk_ready` toggled 1,0,0,1,… → `rk`/`rk_idx` stable across every low cycle; no key skipped or duplicated.
- nk=5 with `start`:
  - `err`=1, `rk_valid` never asserts, FSM stays in IDLE.
  - A later legal `start` clears `err`.
- Mid-stream hazards:
  - `sched_done` dropped after 3 transfers → `rk_valid`=0 and `err`=1 next cycle.
  - `rst` asserted mid-stream → all outputs at their reset values next cycle.
- Macro on, nk=4:
  - Keys 10 and 0 are unchanged.
  - Keys 9..1 equal the software model's InvMixColumns of the plain keys.
